// File: rtl/axi_read_row_scheduler_pkg.sv
// Shared types and constants for the row-by-row AXI read scheduler.
package axi_read_row_scheduler_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int LEN_W_DEF      = 32;
    localparam int ROWS_W_DEF     = 16;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int TIMEOUT_W_DEF  = 20;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/axi_read_row_scheduler_sched_watchdog.sv
// Saturating cycle counter with synchronous clear; expired is high once the count is all ones.
module axi_read_row_scheduler_sched_watchdog #(
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_r;

    assign expired = &count_r;

    // Count enabled cycles, holding at the saturation value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_read_row_scheduler.sv
// Issues one read-master job per feature-map row, stepping the address by a stride,
// with abort, bad-config and watchdog-timeout handling.
module axi_read_row_scheduler
    import axi_read_row_scheduler_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ROWS_W     = ROWS_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [ROWS_W-1:0] cfg_rows,
    input  logic              cfg_abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ROWS_W-1:0] row_idx,
    output logic              rd_apStart,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              rd_apDone
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ROWS_W-1:0] ROW_ONE  = ROWS_W'(1);

    state_e            state_r, state_s;
    logic              busy_r, busy_s, done_r, done_s;
    logic [1:0]        err_r, err_s;
    logic [ROWS_W-1:0] row_idx_r, row_idx_s, rows_r, rows_s, row_inc_s;
    logic              start_r, start_s;
    logic [ADDR_W-1:0] addr_r, addr_s, cur_addr_r, cur_addr_s, stride_r, stride_s;
    logic [LEN_W-1:0]  len_r, len_s, row_len_r, row_len_s;
    logic              abort_r, abort_s, abort_now_s;
    logic [GAP_W-1:0]  gap_r, gap_s;
    logic              wd_clr_s, wd_en_s, wd_expired_s;

    axi_read_row_scheduler_sched_watchdog #(.CNT_W(TIMEOUT_W)) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    assign row_inc_s   = row_idx_r + ROW_ONE;
    assign abort_now_s = abort_r | cfg_abort;

    // Next-state and next-output logic; read-master outputs are zero unless a job is live.
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        err_s      = err_r;
        row_idx_s  = row_idx_r;
        rows_s     = rows_r;
        start_s    = 1'b0;
        addr_s     = '0;
        len_s      = '0;
        cur_addr_s = cur_addr_r;
        stride_s   = stride_r;
        row_len_s  = row_len_r;
        abort_s    = abort_r;
        gap_s      = gap_r;
        wd_clr_s   = 1'b0;
        wd_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (cfg_start) begin
                    if ((cfg_rows != '0) && (cfg_row_len != '0)) begin
                        cur_addr_s = cfg_base;
                        stride_s   = cfg_stride;
                        row_len_s  = cfg_row_len;
                        rows_s     = cfg_rows;
                        row_idx_s  = '0;
                        err_s      = ERR_NONE;
                        busy_s     = 1'b1;
                        start_s    = 1'b1;
                        addr_s     = cfg_base;
                        len_s      = cfg_row_len;
                        state_s    = ST_LAUNCH;
                    end else begin
                        err_s  = ERR_CFG;
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                start_s  = 1'b1;
                addr_s   = addr_r;
                len_s    = len_r;
                wd_clr_s = 1'b1;
                abort_s  = abort_now_s;
                state_s  = ST_WAIT;
            end
            ST_WAIT: begin
                start_s = 1'b1;
                addr_s  = addr_r;
                len_s   = len_r;
                wd_en_s = 1'b1;
                abort_s = abort_now_s;
                if (rd_apDone) begin
                    start_s    = 1'b0;
                    addr_s     = '0;
                    len_s      = '0;
                    row_idx_s  = row_inc_s;
                    cur_addr_s = cur_addr_r + stride_r;
                    if ((row_inc_s == rows_r) || abort_now_s) begin
                        done_s  = 1'b1;
                        state_s = ST_FIN;
                    end else begin
                        gap_s   = '0;
                        state_s = ST_GAP;
                    end
                end else if (wd_expired_s) begin
                    start_s = 1'b0;
                    addr_s  = '0;
                    len_s   = '0;
                    err_s   = ERR_TIMEOUT;
                    done_s  = 1'b1;
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                abort_s = abort_now_s;
                if (abort_now_s) begin
                    done_s  = 1'b1;
                    state_s = ST_FIN;
                end else if (gap_r == GAP_LAST) begin
                    start_s = 1'b1;
                    addr_s  = cur_addr_r;
                    len_s   = row_len_r;
                    state_s = ST_LAUNCH;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            ST_FIN, ST_ERR: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= ERR_NONE;
            row_idx_r  <= '0;
            rows_r     <= '0;
            start_r    <= 1'b0;
            addr_r     <= '0;
            len_r      <= '0;
            cur_addr_r <= '0;
            stride_r   <= '0;
            row_len_r  <= '0;
            abort_r    <= 1'b0;
            gap_r      <= '0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            row_idx_r  <= row_idx_s;
            rows_r     <= rows_s;
            start_r    <= start_s;
            addr_r     <= addr_s;
            len_r      <= len_s;
            cur_addr_r <= cur_addr_s;
            stride_r   <= stride_s;
            row_len_r  <= row_len_s;
            abort_r    <= abort_s;
            gap_r      <= gap_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign row_idx    = row_idx_r;
    assign rd_apStart = start_r;
    assign rd_addr    = addr_r;
    assign rd_len     = len_r;

endmodule
